// File: rtl/pwm_cmd_pkg.sv
// Shared definitions for the PWM command decoder.
// Holds the frame/response byte codes, the command codes and the FSM
// state encoding used by pwm_cmd_regs and pwm_cmd_timeout.
package pwm_cmd_pkg;

  // Frame and response byte codes
  localparam logic [7:0] SOF = 8'hA5;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  // Command codes carried in the second frame byte
  localparam logic [7:0] CMD_WR_PERIOD = 8'h01;
  localparam logic [7:0] CMD_WR_DUTY   = 8'h02;
  localparam logic [7:0] CMD_RD_PERIOD = 8'h03;
  localparam logic [7:0] CMD_RD_DUTY   = 8'h04;

  // FSM state encoding: one state per expected frame byte plus RESP
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CMD  = 3'd1;
  localparam logic [2:0] ST_DHI  = 3'd2;
  localparam logic [2:0] ST_DLO  = 3'd3;
  localparam logic [2:0] ST_CHK  = 3'd4;
  localparam logic [2:0] ST_RESP = 3'd5;

  // True while a frame is partially received (the inter-byte timeout applies)
  function automatic logic in_frame(input logic [2:0] st);
    return (st == ST_CMD) || (st == ST_DHI) || (st == ST_DLO) || (st == ST_CHK);
  endfunction

endpackage

// File: rtl/pwm_cmd_timeout.sv
// Inter-byte timeout for partially received command frames.
// A loadable down-counter: load_i arms it with CYCLES, clr_i parks it at 0,
// en_i counts one idle cycle. expire_o pulses on the CYCLES-th counted
// cycle after the last load.
//   clk, rst   : clock, asynchronous active-high reset
//   load_i     : reload with CYCLES (highest priority)
//   clr_i      : clear to 0
//   en_i       : count one idle cycle
//   expire_o   : combinational pulse, the current idle cycle is the last one
module pwm_cmd_timeout
  import pwm_cmd_pkg::*;
#(
  parameter int unsigned CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CW = $clog2(CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Depends only on the present count and en_i so the owner can steer its
  // FSM from it without closing a combinational loop through load/clr.
  assign expire_o = en_i && (cnt_q == CW'(1));

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CW'(CYCLES);
    end else if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pwm_cmd_regs.sv
// UART command decoder and PWM period/duty register file.
// Parses 5-byte frames (SOF, CMD, DHI, DLO, CHK with CHK = CMD^DHI^DLO),
// updates period/duty on valid writes, and returns ACK / NAK / read data
// to the UART transmitter over a valid/ready handshake.
//   clk, rst           : clock, asynchronous active-high reset
//   rx_data, rx_valid  : received byte and its one-cycle strobe
//   tx_data, tx_valid  : response byte and its valid flag
//   tx_ready           : transmitter accepts tx_data this cycle
//   period, duty       : PWM register outputs (WIDTH bits, WIDTH must be 16)
//   err_cnt            : saturating count of NAKs and timeouts
module pwm_cmd_regs
  import pwm_cmd_pkg::*;
#(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned PERIOD_RST     = 999,
  parameter int unsigned DUTY_RST       = 0,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] duty,
  output logic [7:0]       err_cnt
);

  logic [2:0]       state_q, state_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [7:0]       dhi_q, dhi_d;
  logic [7:0]       dlo_q, dlo_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  // Bytes still queued behind tx_data_q (read responses only)
  logic [7:0]       resp_hi_q, resp_hi_d;
  logic [7:0]       resp_lo_q, resp_lo_d;
  logic [1:0]       resp_left_q, resp_left_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  logic        err_inc;
  logic        tmo_load, tmo_clr, tmo_en, tmo_expire;
  logic [15:0] wr_val, period16, duty16;
  logic        chk_match, cmd_known, zero_period, frame_ok;

  assign wr_val   = {dhi_q, dlo_q};
  assign period16 = 16'(period_q);
  assign duty16   = 16'(duty_q);

  // Evaluated in the CHK state against the incoming checksum byte
  assign chk_match   = (rx_data == (cmd_q ^ dhi_q ^ dlo_q));
  assign cmd_known   = (cmd_q == CMD_WR_PERIOD) || (cmd_q == CMD_WR_DUTY) ||
                       (cmd_q == CMD_RD_PERIOD) || (cmd_q == CMD_RD_DUTY);
  // A zero period would stall the PWM counter, so it is refused
  assign zero_period = (cmd_q == CMD_WR_PERIOD) && (wr_val == 16'd0);
  assign frame_ok    = chk_match && cmd_known && !zero_period;

  // Timer is re-armed by every byte that keeps us inside a frame and parked
  // at zero whenever the next state is outside one.
  assign tmo_en   = in_frame(state_q) && !rx_valid;
  assign tmo_load = rx_valid && in_frame(state_d);
  assign tmo_clr  = !in_frame(state_d);

  pwm_cmd_timeout #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .load_i   (tmo_load),
    .clr_i    (tmo_clr),
    .en_i     (tmo_en),
    .expire_o (tmo_expire)
  );

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    dhi_d       = dhi_q;
    dlo_d       = dlo_q;
    period_d    = period_q;
    duty_d      = duty_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    resp_hi_d   = resp_hi_q;
    resp_lo_d   = resp_lo_q;
    resp_left_d = resp_left_q;
    err_inc     = 1'b0;

    if (in_frame(state_q) && tmo_expire) begin
      // Abandon the partial frame silently; only the error counter records it
      state_d = ST_IDLE;
      err_inc = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rx_valid && (rx_data == SOF)) state_d = ST_CMD;
        end
        ST_CMD: begin
          if (rx_valid) begin
            cmd_d   = rx_data;
            state_d = ST_DHI;
          end
        end
        ST_DHI: begin
          if (rx_valid) begin
            dhi_d   = rx_data;
            state_d = ST_DLO;
          end
        end
        ST_DLO: begin
          if (rx_valid) begin
            dlo_d   = rx_data;
            state_d = ST_CHK;
          end
        end
        ST_CHK: begin
          if (rx_valid) begin
            state_d     = ST_RESP;
            tx_valid_d  = 1'b1;
            resp_left_d = 2'd0;
            if (!frame_ok) begin
              tx_data_d = NAK;
              err_inc   = 1'b1;
            end else begin
              tx_data_d = ACK;
              case (cmd_q)
                CMD_WR_PERIOD: period_d = WIDTH'(wr_val);
                CMD_WR_DUTY:   duty_d   = WIDTH'(wr_val);
                CMD_RD_PERIOD: begin
                  resp_hi_d   = period16[15:8];
                  resp_lo_d   = period16[7:0];
                  resp_left_d = 2'd2;
                end
                CMD_RD_DUTY: begin
                  resp_hi_d   = duty16[15:8];
                  resp_lo_d   = duty16[7:0];
                  resp_left_d = 2'd2;
                end
                default: ;
              endcase
            end
          end
        end
        ST_RESP: begin
          // tx_valid is always high here; rx bytes are dropped
          if (tx_ready) begin
            if (resp_left_q == 2'd0) begin
              tx_valid_d = 1'b0;
              tx_data_d  = 8'h00;
              state_d    = ST_IDLE;
            end else begin
              tx_data_d   = resp_hi_q;
              resp_hi_d   = resp_lo_q;
              resp_left_d = resp_left_q - 2'd1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    err_cnt_d = err_cnt_q;
    if (err_inc && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_q       <= 8'h00;
      dhi_q       <= 8'h00;
      dlo_q       <= 8'h00;
      period_q    <= WIDTH'(PERIOD_RST);
      duty_q      <= WIDTH'(DUTY_RST);
      tx_data_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
      resp_hi_q   <= 8'h00;
      resp_lo_q   <= 8'h00;
      resp_left_q <= 2'd0;
      err_cnt_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      dhi_q       <= dhi_d;
      dlo_q       <= dlo_d;
      period_q    <= period_d;
      duty_q      <= duty_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      resp_hi_q   <= resp_hi_d;
      resp_lo_q   <= resp_lo_d;
      resp_left_q <= resp_left_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign period   = period_q;
  assign duty     = duty_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: doc/pwm_cmd_regs.md
Name: pwm_cmd_regs

Overview:
UART command decoder and register file that sits directly upstream of the centre-aligned PWM generator. It consumes the received byte stream from the UART receiver, parses fixed 5-byte command frames, and holds the period and duty values that drive the PWM inputs. It returns ACK, NAK or read-data bytes to the UART transmitter through a valid/ready handshake.

Parameters:
WIDTH, 16, width of the period and duty registers; must equal the PWM counter width, and 16 is the only supported value (frame carries exactly 2 data bytes)
PERIOD_RST, 999, period value loaded on reset
DUTY_RST, 0, duty value loaded on reset
TIMEOUT_CYCLES, 100000, inter-byte timeout in clk cycles for a partially received frame

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
rx_data  input  8  received byte from the UART receiver
rx_valid  input  1  one-cycle strobe; rx_data is valid this cycle
tx_data  output  8  response byte to the UART transmitter
tx_valid  output  1  response byte available
tx_ready  input  1  transmitter accepts tx_data this cycle
period  output  WIDTH  PWM period register
duty  output  WIDTH  PWM duty register
err_cnt  output  8  saturating count of NAKs and timeouts

Behaviour:
- Reset values: period=PERIOD_RST, duty=DUTY_RST, tx_valid=0, tx_data=0, err_cnt=0, FSM=IDLE, timeout counter=0.
- Frame format: 0xA5, CMD, DHI, DLO, CHK, where CHK = CMD ^ DHI ^ DLO.
- Commands:
  - 0x01: write period.
  - 0x02: write duty.
  - 0x03: read period.
  - 0x04: read duty.
  - For reads, DHI and DLO are don't-care but are still included in CHK.
- FSM states: IDLE, CMD, DHI, DLO, CHK, RESP. Each rx_valid advances one state.
- IDLE: any byte other than 0xA5 is discarded silently.
- CHK byte evaluation:
  - Checksum mismatch, unknown CMD, or write period with value 0: NAK. No register change.
  - Otherwise execute the command and respond.
- Register update timing: on a valid write, period or duty takes {DHI,DLO} on the clock edge after the CHK byte strobe (1-cycle latency).
- Duty is stored unclamped; duty > period yields 100% at the PWM.
- Responses:
  - Write: 1 byte, 0x06.
  - Read: 3 bytes, 0x06, hi, lo. Read data is the register value at the CHK cycle.
  - Error: 1 byte, 0x15.
- RESP state:
  - tx_valid rises the cycle after CHK.
  - tx_data is held stable while tx_valid=1 and tx_ready=0.
  - A byte transfers when tx_valid and tx_ready are both 1; the next byte is presented the following cycle.
  - After the last byte transfers, tx_valid=0 and the FSM returns to IDLE.
- rx_valid while in RESP: byte dropped, no error count. The transmitter is never overrun.
- Timeout: in CMD/DHI/DLO/CHK, the counter increments each cycle without rx_valid and clears on rx_valid. On reaching TIMEOUT_CYCLES, return to IDLE silently and increment err_cnt.
- err_cnt: +1 per NAK and per timeout; saturates at 255.
- Reset mid-frame or mid-response: immediate return to reset values. A partially sent response is abandoned.

Decomposition:
- Shared package pwm_cmd_pkg holds:
  - Constants: SOF=0xA5, ACK=0x06, NAK=0x15, and the CMD codes 0x01..0x04.
  - The FSM state encoding.
- One natural sub-module: pwm_cmd_timeout, a loadable down-counter with a clear input and an expiry pulse output.

Test Plan:
- Write period: A5 01 03 E8 EA -> period=0x03E8 one cycle after the CHK strobe; tx emits 06; err_cnt=0.
- Write duty then read duty: A5 02 01 F4 F7, then A5 04 00 00 04 -> duty=0x01F4; tx emits 06, then 06 01 F4.
- Bad checksum: A5 01 00 10 00 -> tx emits 15; period unchanged at 999; err_cnt=1.
- Period zero: A5 01 00 00 01 -> NAK 15; period unchanged at 999.
- Backpressure: issue a read with tx_ready low for 20 cycles -> tx_data held 06 with tx_valid=1; then 3 bytes in order; extra rx bytes sent during RESP are ignored.
- Timeout and resync: A5 01 then idle TIMEOUT_CYCLES -> IDLE and err_cnt+1; noise 00 FF then a valid frame -> executes normally. Assert rst mid-frame -> period=999, duty=0, tx_valid=0.
